// File: rtl/ped_walk_ctrl.sv
// Pedestrian crossing controller fed by the traffic FSM's one-hot {Red,Yellow,Green} lights.
// Grants WALK only inside a vehicle RED phase, then a blinking DONT_WALK clearance phase.
module ped_walk_ctrl #(
    parameter int unsigned WALK_CYCLES  = 6,
    parameter int unsigned FLASH_CYCLES = 4,
    parameter int unsigned BLINK_HALF   = 1,
    parameter int unsigned CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       lights,
    input  logic             ped_button,
    output logic             walk,
    output logic             dont_walk,
    output logic             req_pending,
    output logic [CNT_W-1:0] countdown,
    output logic             fault
);

    localparam int unsigned      BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [2:0]       LIGHTS_RED = 3'b100;
    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_TOP = BLINK_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WALK  = 2'd1,
        ST_FLASH = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         lights_q;
    logic [CNT_W-1:0]   countdown_q, countdown_d;
    logic [BLINK_W-1:0] blink_tmr_q, blink_tmr_d;
    logic               blink_q, blink_d;
    logic               req_pending_q, req_pending_d;
    logic               walk_q, walk_d;
    logic               dont_walk_q, dont_walk_d;
    logic               fault_q, fault_d;

    logic illegal;
    logic red_on;
    logic red_rise;

    // Lights decode: anything other than exactly one lamp lit is a malformed vector.
    always_comb begin
        illegal  = ($countones(lights) != 1);
        red_on   = lights[2];
        red_rise = (lights == LIGHTS_RED) && (lights_q != LIGHTS_RED);
    end

    // Next-state and registered-output computation; priority is illegal > red drop > phase.
    always_comb begin
        state_d       = state_q;
        countdown_d   = countdown_q;
        blink_d       = blink_q;
        blink_tmr_d   = blink_tmr_q;
        req_pending_d = req_pending_q;

        if (illegal) begin
            state_d       = ST_FAULT;
            countdown_d   = '0;
            blink_d       = 1'b0;
            blink_tmr_d   = '0;
            req_pending_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (red_rise && (req_pending_q || ped_button)) begin
                        state_d       = ST_WALK;
                        countdown_d   = WALK_LOAD;
                        req_pending_d = 1'b0;
                    end else if (ped_button) begin
                        req_pending_d = 1'b1;
                    end
                end

                ST_WALK: begin
                    if (!red_on) begin
                        state_d     = ST_IDLE;
                        countdown_d = '0;
                    end else if (countdown_q == '0) begin
                        state_d     = ST_FLASH;
                        countdown_d = FLASH_LOAD;
                        blink_d     = 1'b1;
                        blink_tmr_d = '0;
                    end else begin
                        countdown_d = countdown_q - CNT_W'(1);
                    end
                end

                ST_FLASH: begin
                    if (ped_button) begin
                        req_pending_d = 1'b1;
                    end
                    if (!red_on || (countdown_q == '0)) begin
                        state_d     = ST_IDLE;
                        countdown_d = '0;
                        blink_d     = 1'b0;
                        blink_tmr_d = '0;
                    end else begin
                        countdown_d = countdown_q - CNT_W'(1);
                        if (blink_tmr_q == BLINK_TOP) begin
                            blink_d     = ~blink_q;
                            blink_tmr_d = '0;
                        end else begin
                            blink_tmr_d = blink_tmr_q + BLINK_W'(1);
                        end
                    end
                end

                ST_FAULT: begin
                    state_d = ST_FAULT;
                end

                default: begin
                    state_d       = ST_FAULT;
                    countdown_d   = '0;
                    req_pending_d = 1'b0;
                end
            endcase
        end

        // Lamp outputs are registered from the next state so they track the phase exactly.
        walk_d      = (state_d == ST_WALK);
        fault_d     = (state_d == ST_FAULT);
        dont_walk_d = (state_d == ST_FLASH) ? blink_d : (state_d != ST_WALK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lights_q      <= LIGHTS_RED;
            countdown_q   <= '0;
            blink_q       <= 1'b0;
            blink_tmr_q   <= '0;
            req_pending_q <= 1'b0;
            walk_q        <= 1'b0;
            dont_walk_q   <= 1'b1;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            lights_q      <= lights;
            countdown_q   <= countdown_d;
            blink_q       <= blink_d;
            blink_tmr_q   <= blink_tmr_d;
            req_pending_q <= req_pending_d;
            walk_q        <= walk_d;
            dont_walk_q   <= dont_walk_d;
            fault_q       <= fault_d;
        end
    end

    assign walk        = walk_q;
    assign dont_walk   = dont_walk_q;
    assign req_pending = req_pending_q;
    assign countdown   = countdown_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_ped_walk_ctrl.sv
// Bench for ped_walk_ctrl: directed crossing scenarios plus randomized traffic,
// scored against a phase-time reference model through an expectation queue.
module tb_ped_walk_ctrl;

    localparam int WALK_CYCLES  = 6;
    localparam int FLASH_CYCLES = 4;
    localparam int BLINK_HALF   = 1;
    localparam int CNT_W        = 4;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       lights = 3'b001;
    logic             ped_button = 1'b0;
    logic             walk;
    logic             dont_walk;
    logic             req_pending;
    logic [CNT_W-1:0] countdown;
    logic             fault;

    int n_checks = 0;
    int n_fail   = 0;

    // expected {walk, dont_walk, req_pending, countdown[3:0], fault}
    logic [7:0] exp_q[$];

    // reference model: remaining cycles per phase, elapsed flash time
    int         m_walk;
    int         m_flash;
    int         m_flash_el;
    bit         m_pend;
    bit         m_fault;
    logic [2:0] m_prev;

    ped_walk_ctrl #(
        .WALK_CYCLES (WALK_CYCLES),
        .FLASH_CYCLES(FLASH_CYCLES),
        .BLINK_HALF  (BLINK_HALF),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lights     (lights),
        .ped_button (ped_button),
        .walk       (walk),
        .dont_walk  (dont_walk),
        .req_pending(req_pending),
        .countdown  (countdown),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_walk     = 0;
        m_flash    = 0;
        m_flash_el = 0;
        m_pend     = 1'b0;
        m_fault    = 1'b0;
        m_prev     = RED;
    endtask

    task automatic model_step(input logic [2:0] l, input logic b);
        bit rr;
        rr = (l == RED) && (m_prev != RED);
        if ($countones(l) != 1) m_fault = 1'b1;
        if (m_fault) begin
            m_walk  = 0;
            m_flash = 0;
            m_pend  = 1'b0;
        end else if ((m_walk > 0 || m_flash > 0) && !l[2]) begin
            if (m_flash > 0 && b) m_pend = 1'b1;
            m_walk  = 0;
            m_flash = 0;
        end else if (m_walk > 0) begin
            m_walk--;
            if (m_walk == 0) begin
                m_flash    = FLASH_CYCLES;
                m_flash_el = 0;
            end
        end else if (m_flash > 0) begin
            if (b) m_pend = 1'b1;
            m_flash--;
            m_flash_el++;
        end else if (rr && (m_pend || b)) begin
            m_walk = WALK_CYCLES;
            m_pend = 1'b0;
        end else if (b) begin
            m_pend = 1'b1;
        end
        m_prev = l;
    endtask

    function automatic logic [7:0] model_out();
        logic       w;
        logic       f;
        logic       dw;
        logic       blink;
        logic [3:0] cd;
        w     = (m_walk > 0);
        f     = (m_flash > 0);
        blink = ((m_flash_el / BLINK_HALF) % 2) == 0;
        dw    = m_fault ? 1'b1 : (w ? 1'b0 : (f ? blink : 1'b1));
        cd    = w ? 4'(m_walk - 1) : (f ? 4'(m_flash - 1) : 4'd0);
        return {w, dw, m_pend, cd, m_fault};
    endfunction

    // Model: each active edge (or async reset assertion) yields the next expected output word.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_reset();
                exp_q.delete();
            end else begin
                model_step(lights, ped_button);
            end
            exp_q.push_back(model_out());
        end
    end

    // Monitor: outputs sampled on the falling edge and scored against the queue.
    initial begin
        logic [7:0] obs;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            obs = {walk, dont_walk, req_pending, countdown, fault};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty t=%0t: got %b expected <none>", $time, obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got %b expected %b (walk,dont_walk,req,cnt,fault)",
                             $time, obs, e);
                end
            end
            n_checks++;
            if (walk === 1'b1 && dont_walk === 1'b1) begin
                n_fail++;
                $display("FAIL lamp_exclusive t=%0t: got walk=1 dont_walk=1 expected not both", $time);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic [2:0] l, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            lights     = l;
            ped_button = b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_phase(input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(l, ($urandom_range(0, 4) == 0), 1);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        lights     = GREEN;
        ped_button = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] bad[5];
        bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

        @(posedge clk);
        #1;
        check("reset_walk", walk, 0);
        check("reset_dont_walk", dont_walk, 1);
        check("reset_countdown", countdown, 0);
        check("reset_fault", fault, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single button press in GREEN, served at the next red rise
        cyc(GREEN, 1'b1, 1);
        check("t2_req_set", req_pending, 1);
        cyc(GREEN, 1'b0, 10);
        cyc(YELLOW, 1'b0, 11);
        check("t2_req_held", req_pending, 1);
        check("t2_no_walk_yet", walk, 0);
        cyc(RED, 1'b0, 1);
        check("t2_walk_on", walk, 1);
        check("t2_req_clear", req_pending, 0);
        check("t2_cnt_start", countdown, 5);
        for (int i = 1; i <= 5; i++) begin
            cyc(RED, 1'b0, 1);
            check("t2_walk_cnt", countdown, 32'(5 - i));
            check("t2_walk_held", walk, 1);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(RED, 1'b0, 1);
            check("t2_flash_walk", walk, 0);
            check("t2_flash_blink", dont_walk, 32'((i % 2) == 0));
            check("t2_flash_cnt", countdown, 32'(3 - i));
        end
        cyc(RED, 1'b0, 1);
        check("t2_idle_dw", dont_walk, 1);
        check("t2_idle_walk", walk, 0);
        check("t2_idle_cnt", countdown, 0);

        // no request across a full traffic cycle
        cyc(GREEN, 1'b0, 11);
        cyc(YELLOW, 1'b0, 11);
        cyc(RED, 1'b0, 11);
        check("t3_walk", walk, 0);
        check("t3_dont_walk", dont_walk, 1);

        // red drops back to green mid-WALK
        cyc(GREEN, 1'b1, 1);
        cyc(GREEN, 1'b0, 3);
        cyc(YELLOW, 1'b0, 3);
        cyc(RED, 1'b0, 3);
        check("t4_cnt3", countdown, 3);
        cyc(GREEN, 1'b0, 1);
        check("t4_walk_off", walk, 0);
        check("t4_dw_on", dont_walk, 1);
        check("t4_cnt0", countdown, 0);

        // asynchronous reset while countdown=3
        cyc(GREEN, 1'b1, 1);
        cyc(YELLOW, 1'b0, 2);
        cyc(RED, 1'b0, 3);
        check("t1_pre_cnt", countdown, 3);
        #1;
        reset = 1'b1;
        #1;
        check("t1_walk", walk, 0);
        check("t1_dont_walk", dont_walk, 1);
        check("t1_cnt", countdown, 0);
        check("t1_req", req_pending, 0);
        lights = GREEN;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // malformed lights vector is sticky
        cyc(3'b110, 1'b0, 1);
        check("t5_fault", fault, 1);
        check("t5_dw", dont_walk, 1);
        cyc(GREEN, 1'b0, 2);
        cyc(RED, 1'b1, 4);
        check("t5_sticky", fault, 1);
        check("t5_no_walk", walk, 0);
        do_reset();
        check("t5_cleared", fault, 0);

        // button held through WALK is not relatched; a FLASH press is
        cyc(GREEN, 1'b1, 2);
        cyc(YELLOW, 1'b1, 2);
        cyc(RED, 1'b1, 1);
        check("t6_walk", walk, 1);
        check("t6_req0", req_pending, 0);
        cyc(RED, 1'b1, 5);
        check("t6_walk_req", req_pending, 0);
        check("t6_walk_cnt0", countdown, 0);
        cyc(RED, 1'b1, 1);
        check("t6_flash_entry_walk", walk, 0);
        check("t6_flash_entry_req", req_pending, 0);
        cyc(RED, 1'b1, 1);
        check("t6_flash_latch", req_pending, 1);
        cyc(RED, 1'b0, 6);
        cyc(GREEN, 1'b0, 3);
        cyc(YELLOW, 1'b0, 2);
        check("t6_req_kept", req_pending, 1);
        cyc(RED, 1'b0, 1);
        check("t6_rewalk", walk, 1);
        check("t6_req_clear", req_pending, 0);

        // randomized traffic with occasional faults and mid-cycle resets
        for (int k = 0; k < 60; k++) begin
            rand_phase(GREEN, $urandom_range(2, 12));
            rand_phase(YELLOW, $urandom_range(1, 4));
            rand_phase(RED, $urandom_range(1, 16));
            if ($urandom_range(0, 9) == 0) begin
                cyc(bad[$urandom_range(0, 4)], 1'b0, 1);
                rand_phase(RED, 3);
                do_reset();
            end else if ($urandom_range(0, 11) == 0) begin
                #1;
                reset = 1'b1;
                @(posedge clk);
                #1;
                lights = GREEN;
                reset  = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
